// File: rtl/program_select_ctl_pkg.sv
// Shared program codes and selector FSM encoding for the program-select path
// and the regfile copy logic.
package program_select_ctl_pkg;

   localparam int unsigned PROG_NONE = 0;
   localparam int unsigned PROG_FIB  = 1;
   localparam int unsigned PROG_SORT = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

endpackage

// File: rtl/program_select_ctl_debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; the clean level only
// follows the synced input after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_sync #(
   parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic clean_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          clean_q, clean_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter holds cycles already seen differing; the last one flips the level.
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      if (sync2_q != clean_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            clean_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean_o = clean_q;

endmodule

// File: rtl/program_select_ctl.sv
// Debounces the four board buttons, drives the regfile program_selector for a
// fixed hold window per program press, and emits load/save strobes.
module program_select_ctl
   import program_select_ctl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 650000,
   parameter int unsigned HOLD_CYCLES     = 4,
   parameter int unsigned SEL_W           = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             btn_l,
   input  logic             btn_r,
   input  logic             btn_u,
   input  logic             btn_d,
   output logic [SEL_W-1:0] program_selector,
   output logic             busy,
   output logic             load_act,
   output logic             save_act
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   // Bit order: 0 = fib (l), 1 = sort (r), 2 = load (u), 3 = save (d)
   logic [3:0]       btn_raw, clean, rise;
   logic [3:0]       prev_q;
   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             load_q, save_q;

   assign btn_raw = {btn_d, btn_u, btn_r, btn_l};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      debounce_sync #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_i  (clock),
         .rst_i  (reset),
         .btn_i  (btn_raw[g]),
         .clean_o(clean[g])
      );
   end

   // Edge is combinational off the registered previous level so the selector
   // and strobes land one cycle after the clean level rises.
   assign rise = clean & ~prev_q;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise[0]) begin
               sel_d   = SEL_W'(PROG_FIB);
               hold_d  = HW'(HOLD_CYCLES);
               state_d = ST_HOLD;
            end else if (rise[1]) begin
               sel_d   = SEL_W'(PROG_SORT);
               hold_d  = HW'(HOLD_CYCLES);
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q <= HW'(1)) begin
               sel_d   = SEL_W'(PROG_NONE);
               hold_d  = '0;
               state_d = ST_RELEASE;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         ST_RELEASE: begin
            sel_d = SEL_W'(PROG_NONE);
            if (!clean[0] && !clean[1]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            sel_d   = SEL_W'(PROG_NONE);
            hold_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q  <= '0;
         state_q <= ST_IDLE;
         sel_q   <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         load_q  <= 1'b0;
         save_q  <= 1'b0;
      end else begin
         prev_q  <= clean;
         state_q <= state_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         load_q  <= rise[2];
         save_q  <= rise[3];
      end
   end

   assign program_selector = sel_q;
   assign busy             = busy_q;
   assign load_act         = load_q;
   assign save_act         = save_q;

endmodule

// File: tb/tb_program_select_ctl.sv
// Directed bench for program_select_ctl with DEBOUNCE_CYCLES=4, HOLD_CYCLES=3;
// expected outputs are hand-derived per relative cycle of each scenario.
module tb_program_select_ctl;

   logic        clock = 1'b0;
   logic        reset;
   logic        btn_l, btn_r, btn_u, btn_d;
   logic [31:0] program_selector;
   logic        busy, load_act, save_act;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned cyc    = 0;

   program_select_ctl #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (3),
      .SEL_W          (32)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .btn_l           (btn_l),
      .btn_r           (btn_r),
      .btn_u           (btn_u),
      .btn_d           (btn_d),
      .program_selector(program_selector),
      .busy            (busy),
      .load_act        (load_act),
      .save_act        (save_act)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
   endtask

   task automatic chk_all(input string tst, input logic [31:0] sel_e, input logic busy_e,
                          input logic load_e, input logic save_e);
      chk({tst, ".sel"},  program_selector, sel_e);
      chk({tst, ".busy"}, {31'd0, busy},     {31'd0, busy_e});
      chk({tst, ".load"}, {31'd0, load_act}, {31'd0, load_e});
      chk({tst, ".save"}, {31'd0, save_act}, {31'd0, save_e});
   endtask

   initial begin
      reset = 1'b1;
      btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
      repeat (3) step();

      // Idle after reset
      reset = 1'b0;
      cyc   = 0;
      repeat (50) begin
         step();
         chk_all("idle", 32'd0, 1'b0, 1'b0, 1'b0);
      end

      // Fib press at 10 held 20 cycles: code 1 on 17..19, busy until clean level falls
      cyc = 0;
      repeat (40) begin
         step();
         chk_all("fib", (cyc >= 17 && cyc <= 19) ? 32'd1 : 32'd0,
                 (cyc >= 17 && cyc <= 36), 1'b0, 1'b0);
         if (cyc == 10) btn_l = 1'b1;
         if (cyc == 30) btn_l = 1'b0;
      end

      // Three-cycle glitch never reaches the clean level
      cyc   = 0;
      repeat (20) begin
         step();
         chk_all("glitch", 32'd0, 1'b0, 1'b0, 1'b0);
         if (cyc == 2) btn_l = 1'b1;
         if (cyc == 5) btn_l = 1'b0;
      end

      // Simultaneous fib/sort, sort during HOLD ignored, then fresh sort press
      cyc   = 0;
      btn_l = 1'b1;
      btn_r = 1'b1;
      repeat (76) begin
         step();
         chk_all("prio",
                 (cyc >= 7  && cyc <= 9)  ? 32'd1 :
                 (cyc >= 27 && cyc <= 29) ? 32'd1 :
                 (cyc >= 62 && cyc <= 64) ? 32'd2 : 32'd0,
                 (cyc >= 7 && cyc <= 18) || (cyc >= 27 && cyc <= 51) || (cyc >= 62 && cyc <= 72),
                 1'b0, 1'b0);
         if (cyc == 12) begin btn_l = 1'b0; btn_r = 1'b0; end
         if (cyc == 20) btn_l = 1'b1;
         if (cyc == 22) btn_r = 1'b1;
         if (cyc == 32) btn_l = 1'b0;
         if (cyc == 45) btn_r = 1'b0;
         if (cyc == 55) btn_r = 1'b1;
         if (cyc == 66) btn_r = 1'b0;
      end

      // Load button held 30 cycles: single strobe at 7
      cyc   = 0;
      btn_u = 1'b1;
      repeat (40) begin
         step();
         chk_all("load", 32'd0, 1'b0, (cyc == 7), 1'b0);
         if (cyc == 30) btn_u = 1'b0;
      end

      // Save strobe coinciding with a fib trigger
      cyc   = 0;
      btn_d = 1'b1;
      btn_l = 1'b1;
      repeat (30) begin
         step();
         chk_all("save_fib", (cyc >= 7 && cyc <= 9) ? 32'd1 : 32'd0,
                 (cyc >= 7 && cyc <= 21), 1'b0, (cyc == 7));
         if (cyc == 15) begin btn_d = 1'b0; btn_l = 1'b0; end
      end

      // Reset mid-HOLD with fib held; retrigger DEBOUNCE_CYCLES+3 after release of reset
      cyc   = 0;
      btn_l = 1'b1;
      repeat (25) begin
         step();
         chk_all("rst_hold",
                 ((cyc >= 7 && cyc <= 8) || (cyc >= 17 && cyc <= 19)) ? 32'd1 : 32'd0,
                 (cyc >= 7 && cyc <= 8) || (cyc >= 17),
                 1'b0, 1'b0);
         if (cyc == 8)  reset = 1'b1;
         if (cyc == 10) reset = 1'b0;
      end
      btn_l = 1'b0;
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/program_select_ctl.md
Name: program_select_ctl

Overview:
Conditions the raw board buttons that select and trigger processor programs, and drives the regfile's program_selector input. It sits directly upstream of the regfile and replaces the ad-hoc button-to-selector logic at the top level. Each button is synchronised and debounced. A debounced press of a program button holds a program code on program_selector for a fixed number of cycles so the regfile can complete its copy, then returns it to zero. It also emits single-cycle load/save strobes.

Parameters:
DEBOUNCE_CYCLES, 650000, consecutive stable cycles required before a clean button level changes (6.5 ms at 100 MHz).
HOLD_CYCLES, 4, cycles program_selector holds a nonzero code; must be >= 2.
SEL_W, 32, width of program_selector.

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
btn_l  input  1  raw async button: run fib program
btn_r  input  1  raw async button: run sort program
btn_u  input  1  raw async button: load request
btn_d  input  1  raw async button: save request
program_selector  output  SEL_W  program code to regfile; 0 = none
busy  output  1  high while in HOLD or RELEASE
load_act  output  1  one-cycle strobe per debounced btn_u press
save_act  output  1  one-cycle strobe per debounced btn_d press

Behaviour:
- Reset (synchronous, active-high): program_selector=0, busy=0, load_act=0, save_act=0, FSM=IDLE. Synchroniser flops, clean levels and debounce counters are cleared to 0. Reset overrides any operation in progress.
- Per button: 2-flop synchroniser, then debounce. The counter increments while the synced value differs from the clean level, and clears whenever they agree. When the count reaches DEBOUNCE_CYCLES, the clean level takes the synced value and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes the clean level.
- Rising edge = clean level 1 this cycle and 0 the previous cycle; this is a registered compare.
- Latency: a raw level change stable from cycle t reaches the clean level at t+2+DEBOUNCE_CYCLES. The resulting output (selector or strobe) is visible at t+3+DEBOUNCE_CYCLES.
- Codes: PROG_NONE=0, PROG_FIB=1, PROG_SORT=2, zero-extended to SEL_W.
- FSM states IDLE, HOLD, RELEASE:
  - IDLE: on a fib edge, program_selector=1, hold counter=HOLD_CYCLES, go to HOLD. On a sort edge (no fib edge), program_selector=2, same counter load, go to HOLD. A simultaneous fib and sort edge selects fib.
  - HOLD: the code is held and the counter decrements each cycle. The nonzero code is visible for exactly HOLD_CYCLES cycles. On the final cycle, program_selector goes to 0 the next cycle and the FSM goes to RELEASE. Fib/sort edges in HOLD are ignored.
  - RELEASE: program_selector=0. Returns to IDLE when the clean fib and clean sort levels are both 0. A button still held never retriggers.
- busy = (state != IDLE), registered alongside the state.
- load_act/save_act: high for exactly one cycle per rising edge, independent of the FSM. They may coincide with a selector change.
- A button held through reset: clean level restarts at 0, so a fresh edge and trigger occur DEBOUNCE_CYCLES+3 cycles after reset deasserts.

Decomposition:
- Shared package: PROG_NONE/PROG_FIB/PROG_SORT constants and the FSM state encoding (2 bits). The future program-select extensions and the regfile's copy logic consume the same constants.
- Sub-module: debounce_sync (synchroniser, counter, clean level; parameter DEBOUNCE_CYCLES), instantiated four times.
- Edge detect and FSM stay in program_select_ctl.

Test Plan (bench sets DEBOUNCE_CYCLES=4, HOLD_CYCLES=3):
- Reset, no buttons -> program_selector=0, busy=0, both strobes 0 for 50 cycles.
- btn_l high at cycle 10, held 20 cycles -> program_selector=1 for exactly cycles 17-19, then 0. busy high from 17 until clean btn_l falls, then 0. No second trigger.
- btn_l glitch high for 3 cycles -> clean never changes; program_selector stays 0.
- btn_l and btn_r rise together -> code 1 only. btn_r pressed during HOLD -> ignored, no code 2 afterward until released and repressed.
- btn_u held 30 cycles -> load_act high exactly one cycle at cycle t+7. btn_d likewise for save_act, including simultaneously with a fib trigger.
- Reset asserted mid-HOLD with btn_l still held -> selector 0 next cycle, FSM IDLE. After reset deasserts, code 1 reappears DEBOUNCE_CYCLES+3 cycles later.
